pipe_barrel_shifter: RTL
========================

# pipe_barrel_shifter

Parametrised, pipelined barrel shifter for the CPU execute path; it replaces fixed-amount shift blocks with one unit covering any amount in `0..WIDTH-1`. It provides logical left, logical right and arithmetic right shifts, plus an optional rotate. It has valid/ready handshakes on both sides, per-stage bubble collapsing, a flush input, and a tag carried alongside each result. It sits between operand select and the writeback mux in the ALU.

## Interface
- `WIDTH`, 32: data width. Power of two, ≥ 4.
- `REG_EVERY`, 2: log-shift stages per pipeline register. Range 1..`LOG`, where `LOG` = `$clog2(WIDTH)`.
- `TAG_W`, 5: width of the pass-through tag (destination register index).
- Derived: `NREG` = ceil(`LOG`/`REG_EVERY`), the number of register stages. For the defaults, `NREG` = 3.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous kill of all in-flight operations.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted this cycle when `in_valid` is also high.
- `in_data` in `WIDTH`: operand.
- `in_shamt` in `LOG`: shift amount.
- `in_op` in 2: operation. 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- `in_tag` in `TAG_W`: opaque tag.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out `WIDTH`: result.
- `out_zero` out 1: high when `out_data` == 0.
- `out_tag` out `TAG_W`: tag of the result.

## Operation
- Log stage `i` (i = 0..`LOG`-1) shifts by 2^i when `shamt[i]` is set. Stages are applied in ascending order.
- After every `REG_EVERY` stages, and after the final stage, a register captures:
  - valid
  - partial data
  - remaining shamt bits
  - op
  - sign bit of the original `in_data`
  - tag
- Fill rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the captured original sign bit in every stage.
  - ROL wraps bits shifted out of the MSB back into the LSB.
- `shamt` = 0 returns `in_data` unchanged for every op.
- Handshake, per register stage `k`:
  - `ready[k] = !valid[k] || ready[k+1]`.
  - The last stage uses `out_ready` as its downstream ready.
  - `in_ready = ready[0] && !flush`.
- A stage loads when its upstream is valid and `ready[k]` is high. Its valid clears when it hands off downstream and nothing enters.
- Bubbles collapse: an empty stage accepts data even while the output is stalled.
- `out_data`, `out_tag` and `out_zero` are held stable while `out_valid && !out_ready`.
- Results leave in acceptance order. No reordering and no drops except on flush.
- `flush`:
  - Clears every valid bit on the next edge.
  - Forces `in_ready` low, so an input presented in the flush cycle is not accepted.
  - A flush while the output is stalled discards the held result.
  - Data registers keep their values and are don't-care once invalid.

## Timing
- Reset values: all stage valids 0, `out_valid` 0, `out_data` 0, `out_tag` 0, `out_zero` 0 (taken from registered zero data), `in_ready` 1 when `flush` is low.
- Latency: a result is accepted at edge `t` and `out_valid` rises after edge `t+NREG-1`. With the defaults, `out_valid` is first visible in the 3rd cycle after the accepting cycle.
- Throughput: one operation per cycle while `out_ready` is held high.
- Capacity: `NREG` operations. `in_ready` falls only when all stages are full and `out_ready` is low.
- Simultaneous input accept and output handoff in a full pipe is legal and sustains full rate.
- `reset` asserted mid-operation clears all valids immediately and asynchronously. The first accept is possible in the first cycle after deassertion.
- `in_ready` is combinational from `out_ready`, `flush` and the registered valids only. There is no path from `in_valid`.

## Configuration
- Macro: `PIPE_BARREL_SHIFTER_ROTATE_EN`.
- Defined: op 11 performs rotate-left by `shamt`.
- Undefined: rotate logic is omitted, and op 11 is decoded as SLL (zero fill).

## Structure
- Package `shifter_pkg` holds:
  - op encodings `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ROL`
  - the 2-bit op typedef `shift_op_t`
  - a helper function computing `NREG` from `WIDTH` and `REG_EVERY`
- Sub-module `shift_stage`: combinational, parameters `WIDTH` and `STEP`. Inputs are data, enable bit, op and sign; output is the shifted data. It is instantiated `LOG` times via generate.
- The top level owns the pipeline registers, the valid/ready chain and the flush logic.

## Test plan
- SLL `0x000000FF` by 8, defaults → `out_data` `0x0000FF00`, `out_zero` 0. `out_valid` rises 3 cycles after accept, and the tag is echoed.
- `0x80000000` by 31:
  - SRA → `0xFFFFFFFF`.
  - SRL → `0x00000001`.
  - SLL → `0x00000000` with `out_zero` 1.
- ROL `0x80000001` by 4 → `0x00000018` with the macro defined. Without it → `0x00000010`.
- Back-to-back inputs with tags 1–6 while `out_ready` is low for 6 cycles:
  - Exactly 3 inputs are accepted, then `in_ready` goes low.
  - After `out_ready` rises, all 6 results emerge in tag order with no gaps after the first.
- `flush` with 3 operations in flight and `in_valid` high → input not accepted, all valids 0 next cycle, no stale output appears afterwards.
- Async `reset` pulse between clock edges mid-stream → `out_valid` drops immediately and all outputs read 0. A new operation after release completes with normal latency.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// pipeline-depth helper. Rotate support is selected by PIPE_BARREL_SHIFTER_ROTATE_EN.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_t;

    // Number of register stages needed to cover all log-shift stages.
    function automatic int calc_nreg(input int width, input int reg_every);
        return ($clog2(width) + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log-shift stage: shifts by the fixed STEP when enabled.
// Rotate is only built when PIPE_BARREL_SHIFTER_ROTATE_EN is defined; otherwise op 11 acts as SLL.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  shift_op_t        i_op,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_shifted;

    // Select the shifted value for this stage's fixed distance.
    always_comb begin
        w_shifted = i_data;
        if (i_en) begin
            case (i_op)
                OP_SLL:  w_shifted = i_data << STEP;
                OP_SRL:  w_shifted = i_data >> STEP;
                // Fill comes from the original operand's sign, not this stage's MSB.
                OP_SRA:  w_shifted = {{STEP{i_sign}}, i_data[WIDTH-1:STEP]};
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
                OP_ROL:  w_shifted = {i_data[WIDTH-1-STEP:0], i_data[WIDTH-1:WIDTH-STEP]};
`else
                OP_ROL:  w_shifted = i_data << STEP;
`endif
                default: w_shifted = i_data;
            endcase
        end else begin
            w_shifted = i_data;
        end
    end

    assign o_data = w_shifted;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready handshakes, bubble collapsing and flush.
// Define PIPE_BARREL_SHIFTER_ROTATE_EN to enable rotate-left on op 11.
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [1:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_zero,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int LOG  = $clog2(WIDTH);
    localparam int NREG = calc_nreg(WIDTH, REG_EVERY);

    logic [NREG-1:0]  r_valid;
    logic [WIDTH-1:0] r_data  [NREG];
    logic [LOG-1:0]   r_shamt [NREG];
    shift_op_t        r_op    [NREG];
    logic [NREG-1:0]  r_sign;
    logic [TAG_W-1:0] r_tag   [NREG];
    logic             r_zero;

    logic [NREG-1:0]  w_ready;
    logic [NREG-1:0]  w_src_valid;
    logic [NREG-1:0]  w_src_sign;
    logic [WIDTH-1:0] w_src_data  [NREG];
    logic [LOG-1:0]   w_src_shamt [NREG];
    shift_op_t        w_src_op    [NREG];
    logic [TAG_W-1:0] w_src_tag   [NREG];
    logic [WIDTH-1:0] w_grp_out   [NREG];

    genvar g, i;

    generate
        for (g = 0; g < NREG; g++) begin : gen_src
            if (g == 0) begin : g_in
                assign w_src_valid[g] = in_valid;
                assign w_src_data[g]  = in_data;
                assign w_src_shamt[g] = in_shamt;
                assign w_src_op[g]    = shift_op_t'(in_op);
                assign w_src_sign[g]  = in_data[WIDTH-1];
                assign w_src_tag[g]   = in_tag;
            end else begin : g_reg
                assign w_src_valid[g] = r_valid[g-1];
                assign w_src_data[g]  = r_data[g-1];
                assign w_src_shamt[g] = r_shamt[g-1];
                assign w_src_op[g]    = r_op[g-1];
                assign w_src_sign[g]  = r_sign[g-1];
                assign w_src_tag[g]   = r_tag[g-1];
            end
            // Unrolled ready chain: stage g stalls only if it and everything after it is full.
            assign w_ready[g] = ~((&r_valid[NREG-1:g]) & ~out_ready);
        end

        for (i = 0; i < LOG; i++) begin : gen_ls
            localparam int G = i / REG_EVERY;
            logic [WIDTH-1:0] w_in;
            logic [WIDTH-1:0] w_out;
            if ((i % REG_EVERY) == 0) begin : g_head
                assign w_in = w_src_data[G];
            end else begin : g_body
                assign w_in = gen_ls[i-1].w_out;
            end
            shift_stage #(
                .WIDTH (WIDTH),
                .STEP  (1 << i)
            ) u_stage (
                .i_data (w_in),
                .i_en   (w_src_shamt[G][i]),
                .i_op   (w_src_op[G]),
                .i_sign (w_src_sign[G]),
                .o_data (w_out)
            );
        end

        for (g = 0; g < NREG; g++) begin : gen_out
            localparam int LAST = (((g + 1) * REG_EVERY) < LOG) ? ((g + 1) * REG_EVERY - 1) : (LOG - 1);
            assign w_grp_out[g] = gen_ls[LAST].w_out;
        end
    endgenerate

    // Pipeline registers: valids follow the handshake, payload loads on accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= {WIDTH{1'b0}};
                r_shamt[k] <= {LOG{1'b0}};
                r_op[k]    <= OP_SLL;
                r_sign[k]  <= 1'b0;
                r_tag[k]   <= {TAG_W{1'b0}};
            end
            r_zero <= 1'b0;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_ready[k]) begin
                    r_valid[k] <= w_src_valid[k];
                end else begin
                    r_valid[k] <= r_valid[k];
                end
                if (w_ready[k] && w_src_valid[k]) begin
                    r_data[k]  <= w_grp_out[k];
                    r_shamt[k] <= w_src_shamt[k];
                    r_op[k]    <= w_src_op[k];
                    r_sign[k]  <= w_src_sign[k];
                    r_tag[k]   <= w_src_tag[k];
                end
            end
            if (w_ready[NREG-1] && w_src_valid[NREG-1]) begin
                r_zero <= (w_grp_out[NREG-1] == {WIDTH{1'b0}});
            end
        end
    end

    assign in_ready  = w_ready[0] & ~flush;
    assign out_valid = r_valid[NREG-1];
    assign out_data  = r_data[NREG-1];
    assign out_tag   = r_tag[NREG-1];
    assign out_zero  = r_zero;

endmodule
